// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and sizing constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W = 3;
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port word array, byte-enabled synchronous write, asynchronous read
module dmem_sram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DEPTH_LOG2-1:0]   i_addr,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic [DATA_W/8-1:0]     i_be,
    output logic [DATA_W-1:0]       o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_resp_ctrl.sv
// rtl/dmem_resp_ctrl.sv - M-stage data-memory responder: zero-wait stores, RD_LAT-stalled loads
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_resp_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy
`ifdef DMEM_ALIGN_CHK_EN
    ,
    output logic                err_misalign
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DEPTH_LOG2-1:0]  r_addr;
    logic                   r_rsp_valid;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_busy;
    logic                   r_ld_mis;

    logic [DEPTH_LOG2-1:0]  w_word;
    logic                   w_idle;
    logic                   w_st;
    logic                   w_ld_acc;
    logic                   w_ld_mis_now;
    logic                   w_mem_we;
    logic [DEPTH_LOG2-1:0]  w_mem_addr;
    logic [DATA_W-1:0]      w_mem_rdata;
    logic [DATA_W-1:0]      w_rd_now;
    logic [DATA_W-1:0]      w_rd_wait;
    logic [CNT_W-1:0]       w_cnt_dec;
    logic                   w_unused_addr;

    assign w_word    = req_addr[DEPTH_LOG2+1:2];
    assign w_idle    = (r_state == IDLE);
    assign w_st      = w_idle & req_valid & req_we;
    assign w_ld_acc  = w_idle & req_valid & ~req_we;
    assign w_cnt_dec = r_cnt - CNT_W'(1);
    assign w_unused_addr = ^{req_addr[ADDR_W-1:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    logic w_st_mis;
    logic r_err_ld;

    assign w_st_mis     = (req_addr[1:0] != 2'b00) && (req_be == BE_WORD);
    assign w_ld_mis_now = (req_addr[1:0] != 2'b00);
    assign w_mem_we     = w_st & ~w_st_mis;
    // Store faults are reported in the accepting cycle, load faults alongside rsp_valid.
    assign err_misalign = r_err_ld | (w_st & w_st_mis & ~rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ld <= 1'b0;
        end else if (w_ld_acc && RD_LAT == 1) begin
            r_err_ld <= w_ld_mis_now;
        end else if (r_state == WAIT && req_valid && w_cnt_dec == '0) begin
            r_err_ld <= r_ld_mis;
        end else begin
            r_err_ld <= 1'b0;
        end
    end
`else
    assign w_ld_mis_now = 1'b0;
    assign w_mem_we     = w_st;
`endif

    // The array is single-ported: the request address is used while idle, the latched one while waiting.
    assign w_mem_addr = w_idle ? w_word : r_addr;
    assign w_rd_now   = w_ld_mis_now ? '0 : w_mem_rdata;
    assign w_rd_wait  = r_ld_mis ? '0 : w_mem_rdata;

    dmem_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (req_wdata),
        .i_be    (req_be),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_ld_mis    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ld_acc) begin
                        r_addr   <= w_word;
                        r_ld_mis <= w_ld_mis_now;
                        r_busy   <= 1'b1;
                        // A single-cycle latency has no WAIT cycle at all.
                        if (RD_LAT == 1) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rd_now;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (!req_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_dec == '0) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rd_wait;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b1;
        case (r_state)
            IDLE:    req_ready = ~(req_valid & ~req_we);
            WAIT:    req_ready = 1'b0;
            default: req_ready = 1'b1;
        endcase
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// tb/tb_dmem_resp_ctrl.sv - randomized bench for dmem_resp_ctrl at several read latencies
module tb_dmem_resp_ctrl;

    localparam int NI = 4;
    localparam int LATS [NI] = '{2, 1, 3, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        req_ready [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        busy      [NI];
`ifdef DMEM_ALIGN_CHK_EN
    logic        err_misalign [NI];
`endif

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            dmem_resp_ctrl #(
                .ADDR_W     (32),
                .DATA_W     (32),
                .DEPTH_LOG2 (10),
                .RD_LAT     (LATS[g])
            ) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .req_valid (req_valid[g]),
                .req_we    (req_we[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_be    (req_be[g]),
                .req_ready (req_ready[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_rdata (rsp_rdata[g]),
                .busy      (busy[g])
`ifdef DMEM_ALIGN_CHK_EN
                ,
                .err_misalign (err_misalign[g])
`endif
            );
        end
    endgenerate

    logic [31:0] model_mem [NI][1024];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            step();
            req_valid[k] = 1'b0;
            @(negedge clk);
            chk("idle_ready", req_ready[k], 1);
            chk("idle_rsp_valid", rsp_valid[k], 0);
            chk("idle_busy", busy[k], 0);
        end
    endtask

    task automatic do_store(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic mis;
        mis = is_mis(a) && (be == 4'hF);
        step();
        req_valid[k] = 1'b1; req_we[k] = 1'b1;
        req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
        @(negedge clk);
        chk("st_ready", req_ready[k], 1);
        chk("st_busy", busy[k], 0);
`ifdef DMEM_ALIGN_CHK_EN
        chk("st_err", err_misalign[k], mis);
`endif
        if (!mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[k][a[11:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_load(input int k, input logic [31:0] a);
        int lat;
        logic [31:0] exp;
        lat = LATS[k];
        exp = is_mis(a) ? 32'h0 : model_mem[k][a[11:2]];
        step();
        req_valid[k] = 1'b1; req_we[k] = 1'b0;
        req_addr[k] = a; req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) req_addr[k] = $urandom;
            end
            @(negedge clk);
            chk("ld_ready", req_ready[k], (c == lat) ? 1 : 0);
            chk("ld_rsp_valid", rsp_valid[k], (c == lat) ? 1 : 0);
            chk("ld_busy", busy[k], (c > 0) ? 1 : 0);
`ifdef DMEM_ALIGN_CHK_EN
            chk("ld_err", err_misalign[k], (c == lat && is_mis(a)) ? 1 : 0);
`endif
        end
        chk("ld_rdata", rsp_rdata[k], exp);
    endtask

    task automatic do_abort(input int k, input logic [31:0] a, input int j);
        step();
        req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = a;
        @(negedge clk);
        chk("ab_ready_acc", req_ready[k], 0);
        for (int c = 1; c < j; c++) begin
            step();
            @(negedge clk);
            chk("ab_ready_wait", req_ready[k], 0);
            chk("ab_rsp_wait", rsp_valid[k], 0);
        end
        step();
        req_valid[k] = 1'b0;
        @(negedge clk);
        chk("ab_ready_drop", req_ready[k], 0);
        chk("ab_busy_drop", busy[k], 1);
        do_idle(k, 3);
    endtask

    logic [31:0] rnd_addr;
    int op;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_busy", busy[k], 0);
        end

        do_store(0, 32'h10, 32'hDEADBEEF, 4'hF);
        do_load(0, 32'h10);
        chk("raw_data", rsp_rdata[0], 32'hDEADBEEF);

        do_store(0, 32'h20, 32'h11223344, 4'hF);
        do_store(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_load(0, 32'h20);
        chk("be_merge", rsp_rdata[0], 32'h11BB33DD);

        do_store(0, 32'h0, 32'hCAFEF00D, 4'hF);
        do_load(0, 32'h1000);
        chk("wrap_data", rsp_rdata[0], 32'hCAFEF00D);

        step();
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rstw_busy", busy[0], 0);
        chk("rstw_rsp_valid", rsp_valid[0], 0);
        chk("rstw_ready", req_ready[0], 1);
        chk("rstw_rdata", rsp_rdata[0], 0);
        do_idle(0, 3);

`ifdef DMEM_ALIGN_CHK_EN
        do_store(0, 32'h22, 32'h55555555, 4'hF);
        do_load(0, 32'h20);
        chk("mis_st_keep", rsp_rdata[0], 32'h11BB33DD);
        do_load(0, 32'h21);
        chk("mis_ld_zero", rsp_rdata[0], 32'h0);
`endif

        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++) do_store(k, 32'(w) << 2, $urandom, 4'hF);
            for (int n = 0; n < 80; n++) begin
                rnd_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
`ifndef DMEM_ALIGN_CHK_EN
                rnd_addr = rnd_addr | 32'($urandom_range(0, 3));
`endif
                op = $urandom_range(0, 9);
                if (op < 4) do_store(k, rnd_addr, $urandom, 4'($urandom));
                else if (op < 8) do_load(k, rnd_addr);
                else if (op == 9 && LATS[k] >= 2) do_abort(k, rnd_addr, $urandom_range(1, LATS[k] - 1));
                else do_idle(k, 1);
            end
            do_idle(k, 1);
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_resp_ctrl.md
Name: dmem_resp_ctrl

Overview:
- Data-memory responder on the memory-stage side of the RV32 pipeline. It is the slave end of the stall handshake that the pipeline valid/stall controller consumes.
- Accepts load/store requests from the M stage and stalls loads for a fixed number of wait cycles via `req_ready`. It returns load data with a one-cycle `rsp_valid` pulse aligned with release of the stall.
- Stores complete with zero wait states and are byte-enabled.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; fixed at 32 for RV32, and `req_be` is DATA_W/8 bits.
- DEPTH_LOG2, 10, log2 of the number of words in the array.
- RD_LAT, 2, load wait cycles. Legal range 1..7; 2 matches the pipeline's two-cycle memory stall.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- req_valid  in  1  M stage presents an access; held stable by the pipeline while stalled
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, lane-aligned
- req_be  in  DATA_W/8  byte enables for stores; ignored for loads (full word returned)
- req_ready  out  1  0 = stall the pipeline (drives mem_waiting = ~req_ready)
- rsp_valid  out  1  load data valid, one-cycle pulse
- rsp_rdata  out  DATA_W  load data; held until the next rsp_valid
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: state = IDLE; rsp_valid = 0; rsp_rdata = 0; busy = 0; latched address = 0; wait counter = 0. Array contents are not cleared.
- State IDLE, `req_ready` (combinational) = ~(req_valid & ~req_we):
  - req_valid & req_we: write the array at the clock edge, only lanes with req_be[i] = 1. Stay in IDLE.
  - req_valid & ~req_we: latch the word address, set counter = RD_LAT-1, go to WAIT.
  - req_valid = 0: idle, req_ready = 1.
- State WAIT, req_ready = 0:
  - Counter decrements each cycle.
  - When counter == 0: register `array[latched addr]` into rsp_rdata and go to DONE.
  - If req_valid drops (flush or protocol abort): go to IDLE with no rsp_valid.
- State DONE, req_ready = 1, rsp_valid = 1:
  - The held load retires this cycle. Next state is IDLE.
  - A new request presented in the DONE cycle is not accepted; the pipeline advances the held load and presents the next access in the following cycle.
- Load timing: load first presented in cycle T. req_ready is low for cycles T..T+RD_LAT-1. req_ready = 1 and rsp_valid = 1 with data in cycle T+RD_LAT. Total occupancy is RD_LAT+1 cycles.
- Addressing:
  - Word index = req_addr[DEPTH_LOG2+1:2].
  - Higher bits are ignored, so addresses wrap modulo the array size.
  - addr[1:0] is ignored unless DMEM_ALIGN_CHK_EN is defined.
- Read after write: a store in cycle T followed by a load of the same word at T+1 returns the stored data.
- Address changes on req_addr during WAIT are ignored; the latched address is used.
- rst asserted mid-WAIT or in DONE: return to IDLE next edge, rsp_valid = 0, no rsp_valid pulse for the aborted load.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined: adds output `err_misalign` (1 bit, reset 0), driven with one-cycle pulses.
  - Store with req_be == all-ones and addr[1:0] != 0: write suppressed; err_misalign pulses in the accepting cycle.
  - Load with addr[1:0] != 0: normal wait sequence, but rsp_rdata = 0; err_misalign pulses with rsp_valid.
- Not defined: no port; addr[1:0] is ignored for all accesses.

Decomposition:
- Package dmem_pkg:
  - State encoding localparams: IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2.
  - RD_LAT_MAX = 7.
  - Counter width = 3.
  - BE_WORD = 4'hF.
- One sub-module, dmem_sram: single-port, synchronous write, byte-enabled array with DEPTH_LOG2/DATA_W parameters and a read address/data interface. The FSM, counter and handshake stay in dmem_resp_ctrl.

Test Plan:
- Reset mid-WAIT: load issued, rst asserted the next cycle -> state IDLE, rsp_valid never pulses, req_ready = 1 after reset.
- Store then load:
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF at cycle T -> req_ready = 1 at T.
  - Load 0x10 at T+1 -> req_ready low at T+1 and T+2; rsp_valid = 1, rsp_rdata = 0xDEADBEEF at T+3 (RD_LAT = 2).
- Byte-enable merge: word 0x20 = 0x11223344, then store 0xAABBCCDD with be 4'b0101 -> subsequent load of 0x20 returns 0x11BB33DD.
- RD_LAT sweep 1, 3, 7: load -> req_ready low for exactly RD_LAT cycles, rsp_valid a single cycle; busy matches.
- Abort and wrap:
  - req_valid dropped in WAIT -> IDLE with no rsp_valid.
  - Load of addr 0x1000 with DEPTH_LOG2 = 10 -> returns contents of word 0.
- DMEM_ALIGN_CHK_EN:
  - Store be 4'hF to 0x22 -> err_misalign pulses; word 0x20 unchanged.
  - Load 0x21 -> rsp_rdata = 0 and err_misalign pulses with rsp_valid.
